// File: rtl/mdr_read_seq_pkg.sv
// Shared types and constants for the MDR read sequencer.
package mdr_read_seq_pkg;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;
  localparam int LAT_CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HI,
    ST_WAIT_HI,
    ST_RD_LO,
    ST_WAIT_LO,
    ST_DONE
  } state_t;

  // Saturates an out-of-range latency into the supported window.
  function automatic int clamp_lat(input int lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mdr_read_seq_lat_cnt.sv
// Memory latency counter shared by both WAIT states; hit_next is the one-cycle look-ahead
// used to register the shift-register write strobes.
module mdr_read_seq_lat_cnt
  import mdr_read_seq_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit,
  output logic hit_next
);

  localparam logic [LAT_CNT_W-1:0] LAT = LAT_CNT_W'(MEM_LAT);

  logic [LAT_CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + LAT_CNT_W'(1);
    end
  end

  assign hit      = (count == LAT);
  assign hit_next = en && !clr && ((count + LAT_CNT_W'(1)) == LAT);

endmodule

// File: rtl/mdr_read_seq.sv
// MDR read sequencer: issues byte reads and drives the MDR shift-register strobes.
// Optional misaligned word-read trap: define MDR_READ_SEQ_ALIGN_CHECK_EN.
module mdr_read_seq
  import mdr_read_seq_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_word,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              byte_high_we,
  output logic              byte_low_we,
  output logic              byte_high_rst
);

  localparam int LAT_EFF = clamp_lat(MEM_LAT);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              in_rd;
  logic              in_wait;
  logic              cnt_en;
  logic              cnt_clr;
  logic              cnt_hit;
  logic              cnt_hit_next;

  assign in_rd   = (state == ST_RD_HI)   || (state == ST_RD_LO);
  assign in_wait = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);

  // Counting starts in the read cycle so the count equals elapsed latency inside WAIT;
  // leaving a WAIT state clears it for the next byte.
  assign cnt_en  = in_rd || in_wait;
  assign cnt_clr = !cnt_en || (in_wait && cnt_hit);

  mdr_read_seq_lat_cnt #(
    .MEM_LAT (LAT_EFF)
  ) u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .hit      (cnt_hit),
    .hit_next (cnt_hit_next)
  );

`ifndef MDR_READ_SEQ_ALIGN_CHECK_EN
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      mem_addr      <= '0;
      mem_rd        <= 1'b0;
      req_ready     <= 1'b1;
      done          <= 1'b0;
      byte_high_we  <= 1'b0;
      byte_low_we   <= 1'b0;
      byte_high_rst <= 1'b0;
`ifdef MDR_READ_SEQ_ALIGN_CHECK_EN
      err           <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low every cycle, so each one is a single-cycle pulse unless re-armed.
      mem_rd        <= 1'b0;
      done          <= 1'b0;
      byte_high_we  <= 1'b0;
      byte_low_we   <= 1'b0;
      byte_high_rst <= 1'b0;
`ifdef MDR_READ_SEQ_ALIGN_CHECK_EN
      err           <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
`ifdef MDR_READ_SEQ_ALIGN_CHECK_EN
            if (req_word && req_addr[0]) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else
`endif
            begin
              mem_rd   <= 1'b1;
              mem_addr <= req_addr;
              if (req_word) begin
                state <= ST_RD_HI;
              end else begin
                state         <= ST_RD_LO;
                byte_high_rst <= 1'b1;
              end
            end
          end
        end
        ST_RD_HI: begin
          state        <= ST_WAIT_HI;
          byte_high_we <= cnt_hit_next;
        end
        ST_WAIT_HI: begin
          if (cnt_hit) begin
            state    <= ST_RD_LO;
            mem_rd   <= 1'b1;
            mem_addr <= addr_q + ADDR_W'(1);
          end else begin
            byte_high_we <= cnt_hit_next;
          end
        end
        ST_RD_LO: begin
          state       <= ST_WAIT_LO;
          byte_low_we <= cnt_hit_next;
        end
        ST_WAIT_LO: begin
          if (cnt_hit) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            byte_low_we <= cnt_hit_next;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_read_seq.sv
// Scoreboard bench for mdr_read_seq: two instances (MEM_LAT 1 and 3) with a memory and
// MDR shift-register model; expected strobe events are queued at request time.
module tb_mdr_read_seq;

  localparam int L0 = 1;
  localparam int L1 = 3;

  typedef enum logic [2:0] {EV_RD, EV_HRST, EV_HWE, EV_LWE, EV_DONE, EV_ERR, EV_READY} ev_kind_t;
  typedef struct packed {
    int          cyc;
    logic        k;
    ev_kind_t    kind;
    logic [15:0] addr;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [2];
  logic        req_word  [2];
  logic [15:0] req_addr  [2];
  logic        req_ready [2];
  logic        done      [2];
  logic        err       [2];
  logic        mem_rd    [2];
  logic        hwe       [2];
  logic        lwe       [2];
  logic        hrst      [2];
  logic [15:0] mem_addr  [2];

  always #5 clk = ~clk;

  mdr_read_seq #(.ADDR_W(16), .MEM_LAT(L0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_word(req_word[0]), .done(done[0]), .err(err[0]),
    .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .byte_high_we(hwe[0]),
    .byte_low_we(lwe[0]), .byte_high_rst(hrst[0])
  );

  mdr_read_seq #(.ADDR_W(16), .MEM_LAT(L1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_word(req_word[1]), .done(done[1]), .err(err[1]),
    .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .byte_high_we(hwe[1]),
    .byte_low_we(lwe[1]), .byte_high_rst(hrst[1])
  );

  // Memory and shift-register model
  logic [7:0]  mem  [0:65535];
  logic [7:0]  pipe [2][8];
  logic [15:0] sr   [2];
  logic        preload_en [2];
  logic [15:0] preload_val;
  int          cyc = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? L0 : L1;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (preload_en[k]) begin
        sr[k] <= preload_val;
      end else begin
        if (hrst[k]) sr[k][15:8] <= 8'h00;
        if (hwe[k])  sr[k][15:8] <= pipe[k][lat_of(k)-1];
        if (lwe[k])  sr[k][7:0]  <= pipe[k][lat_of(k)-1];
      end
      for (int i = 7; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
      pipe[k][0] <= mem_rd[k] ? mem[mem_addr[k]] : 8'hxx;
    end
  end

  ev_t         exp_q [$];
  ev_t         act_q [$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_sr;
  logic        prev_rdy [2];

  function automatic ev_t mk(input int c, input int k, input ev_kind_t kd, input logic [15:0] a);
    ev_t e;
    e.cyc  = c;
    e.k    = k[0];
    e.kind = kd;
    e.addr = a;
    return e;
  endfunction

  // One cycle of monitoring: record strobe events and check strobe exclusivity.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (mem_rd[k]) act_q.push_back(mk(cyc, k, EV_RD, mem_addr[k]));
      if (hrst[k])   act_q.push_back(mk(cyc, k, EV_HRST, 16'h0));
      if (hwe[k])    act_q.push_back(mk(cyc, k, EV_HWE, 16'h0));
      if (lwe[k])    act_q.push_back(mk(cyc, k, EV_LWE, 16'h0));
      if (done[k])   act_q.push_back(mk(cyc, k, EV_DONE, 16'h0));
      if (err[k])    act_q.push_back(mk(cyc, k, EV_ERR, 16'h0));
      if (req_ready[k] && !prev_rdy[k]) act_q.push_back(mk(cyc, k, EV_READY, 16'h0));
      prev_rdy[k] = req_ready[k];
      checks++;
      if (hrst[k] && hwe[k]) begin
        failures++;
        $display("FAIL excl_hrst_hwe dut%0d cycle %0d: byte_high_rst=1 byte_high_we=1, required not both", k, cyc);
      end
      checks++;
      if (hwe[k] && lwe[k]) begin
        failures++;
        $display("FAIL excl_hwe_lwe dut%0d cycle %0d: byte_high_we=1 byte_low_we=1, required not both", k, cyc);
      end
    end
  endtask

  // Push the expected event timeline and final shift-register value for one request.
  task automatic expect_req(input int k, input logic [15:0] a, input logic w, input int c0,
                            output int last);
    int          l;
    bit          mis;
    logic [15:0] a1;
    l   = lat_of(k);
    a1  = a + 16'd1;
    mis = 1'b0;
`ifdef MDR_READ_SEQ_ALIGN_CHECK_EN
    mis = w && a[0];
`endif
    if (mis) begin
      exp_q.push_back(mk(c0 + 1, k, EV_DONE, 16'h0));
      exp_q.push_back(mk(c0 + 1, k, EV_ERR, 16'h0));
      exp_q.push_back(mk(c0 + 2, k, EV_READY, 16'h0));
      exp_sr = sr[k];
      last   = c0 + 2;
    end else if (w) begin
      exp_q.push_back(mk(c0 + 1,         k, EV_RD,    a));
      exp_q.push_back(mk(c0 + 1 + l,     k, EV_HWE,   16'h0));
      exp_q.push_back(mk(c0 + 2 + l,     k, EV_RD,    a1));
      exp_q.push_back(mk(c0 + 2 + 2 * l, k, EV_LWE,   16'h0));
      exp_q.push_back(mk(c0 + 3 + 2 * l, k, EV_DONE,  16'h0));
      exp_q.push_back(mk(c0 + 4 + 2 * l, k, EV_READY, 16'h0));
      exp_sr = {mem[a], mem[a1]};
      last   = c0 + 4 + 2 * l;
    end else begin
      exp_q.push_back(mk(c0 + 1,     k, EV_RD,    a));
      exp_q.push_back(mk(c0 + 1,     k, EV_HRST,  16'h0));
      exp_q.push_back(mk(c0 + 1 + l, k, EV_LWE,   16'h0));
      exp_q.push_back(mk(c0 + 2 + l, k, EV_DONE,  16'h0));
      exp_q.push_back(mk(c0 + 3 + l, k, EV_READY, 16'h0));
      exp_sr = {8'h00, mem[a]};
      last   = c0 + 3 + l;
    end
  endtask

  task automatic issue(input int k, input logic [15:0] a, input logic w, output int c0);
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    req_word[k]  = w;
    c0 = cyc;
  endtask

  task automatic preload(input int k, input logic [15:0] v);
    preload_val   = v;
    preload_en[k] = 1'b1;
    tick();
    preload_en[k] = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    int          c0;
    int          n_done;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      obs = {req_ready[k], mem_rd[k], hwe[k], lwe[k], hrst[k], done[k], err[k], mem_addr[k]};
      checks++;
      if (obs !== {1'b1, 6'b000000, 16'h0000}) begin
        failures++;
        $display("FAIL reset_state dut%0d: got %h, required %h", k, obs, {1'b1, 6'b000000, 16'h0000});
      end
    end
    rst_n = 1'b1;
    repeat (2) tick();
    act_q.delete();
    issue(1, 16'h0100, 1'b1, c0);
    tick();
    req_valid[1] = 1'b0;
    while (cyc < c0 + 2) tick();
    rst_n = 1'b0;
    #1;
    obs = {req_ready[1], mem_rd[1], hwe[1], lwe[1], hrst[1], done[1], err[1], mem_addr[1]};
    checks++;
    if (obs !== {1'b1, 6'b000000, 16'h0000}) begin
      failures++;
      $display("FAIL reset_mid_wait: got %h, required %h", obs, {1'b1, 6'b000000, 16'h0000});
    end
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    n_done = 0;
    foreach (act_q[i]) if (act_q[i].kind == EV_DONE) n_done++;
    checks++;
    if (n_done !== 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d done pulses, required 0", n_done);
    end
    act_q.delete();
  endtask

  task automatic test_word_read();
    int          c0, last;
    ev_t         e, a;
    logic [15:0] addrs [2];
    addrs[0] = 16'h0010;
    addrs[1] = 16'h0200;
    for (int k = 0; k < 2; k++) begin
      exp_q.delete();
      act_q.delete();
      issue(k, addrs[k], 1'b1, c0);
      expect_req(k, addrs[k], 1'b1, c0, last);
      tick();
      req_valid[k] = 1'b0;
      while (cyc < last + 2) tick();
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act_q.size() == 0) begin
          failures++;
          $display("FAIL word_read dut%0d: got nothing, required %s@%0d", k, e.kind.name(), e.cyc);
        end else begin
          a = act_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL word_read dut%0d: got %s@%0d addr=%h, required %s@%0d addr=%h",
                     k, a.kind.name(), a.cyc, a.addr, e.kind.name(), e.cyc, e.addr);
          end
        end
      end
      checks++;
      if (act_q.size() != 0) begin
        failures++;
        $display("FAIL word_read_extra dut%0d: got %0d extra events, required 0", k, act_q.size());
      end
      checks++;
      if (sr[k] !== exp_sr) begin
        failures++;
        $display("FAIL word_read_value dut%0d: got %h, required %h", k, sr[k], exp_sr);
      end
    end
  endtask

  task automatic test_byte_read();
    int          c0, last;
    ev_t         e, a;
    logic [15:0] addrs [2];
    addrs[0] = 16'h0042;
    addrs[1] = 16'h0021;
    for (int k = 1; k >= 0; k--) begin
      preload(k, (k == 1) ? 16'hFFFF : 16'hA5A5);
      exp_q.delete();
      act_q.delete();
      issue(k, addrs[k], 1'b0, c0);
      expect_req(k, addrs[k], 1'b0, c0, last);
      tick();
      req_valid[k] = 1'b0;
      while (cyc < last + 2) tick();
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act_q.size() == 0) begin
          failures++;
          $display("FAIL byte_read dut%0d: got nothing, required %s@%0d", k, e.kind.name(), e.cyc);
        end else begin
          a = act_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL byte_read dut%0d: got %s@%0d addr=%h, required %s@%0d addr=%h",
                     k, a.kind.name(), a.cyc, a.addr, e.kind.name(), e.cyc, e.addr);
          end
        end
      end
      checks++;
      if (act_q.size() != 0) begin
        failures++;
        $display("FAIL byte_read_extra dut%0d: got %0d extra events, required 0", k, act_q.size());
      end
      checks++;
      if (sr[k] !== exp_sr) begin
        failures++;
        $display("FAIL byte_read_value dut%0d: got %h, required %h", k, sr[k], exp_sr);
      end
    end
  endtask

  // Address wrap and misaligned word reads; the misaligned outcome depends on the build.
  task automatic test_boundaries();
    int          c0, last;
    ev_t         e, a;
    int          ks    [2];
    logic [15:0] addrs [2];
`ifdef MDR_READ_SEQ_ALIGN_CHECK_EN
    ks[0] = 0; addrs[0] = 16'h0003;
`else
    ks[0] = 0; addrs[0] = 16'hFFFF;
`endif
    ks[1] = 1; addrs[1] = 16'h0003;
    for (int n = 0; n < 2; n++) begin
      preload(ks[n], 16'h1357);
      exp_q.delete();
      act_q.delete();
      issue(ks[n], addrs[n], 1'b1, c0);
      expect_req(ks[n], addrs[n], 1'b1, c0, last);
      tick();
      req_valid[ks[n]] = 1'b0;
      while (cyc < last + 2) tick();
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act_q.size() == 0) begin
          failures++;
          $display("FAIL boundary addr=%h: got nothing, required %s@%0d", addrs[n], e.kind.name(), e.cyc);
        end else begin
          a = act_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL boundary addr=%h: got %s@%0d addr=%h, required %s@%0d addr=%h",
                     addrs[n], a.kind.name(), a.cyc, a.addr, e.kind.name(), e.cyc, e.addr);
          end
        end
      end
      checks++;
      if (act_q.size() != 0) begin
        failures++;
        $display("FAIL boundary_extra addr=%h: got %0d extra events, required 0", addrs[n], act_q.size());
      end
      checks++;
      if (sr[ks[n]] !== exp_sr) begin
        failures++;
        $display("FAIL boundary_value addr=%h: got %h, required %h", addrs[n], sr[ks[n]], exp_sr);
      end
    end
  endtask

  task automatic test_back_to_back();
    int  c0, c0b, last, lastb;
    ev_t e, a;
    exp_q.delete();
    act_q.delete();
    issue(1, 16'h0300, 1'b1, c0);
    expect_req(1, 16'h0300, 1'b1, c0, last);
    c0b = c0 + 4 + 2 * L1;
    expect_req(1, 16'h0305, 1'b0, c0b, lastb);
    tick();
    req_addr[1] = 16'h0305;
    req_word[1] = 1'b0;
    while (cyc < c0b + 1) tick();
    req_valid[1] = 1'b0;
    while (cyc < lastb + 2) tick();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act_q.size() == 0) begin
        failures++;
        $display("FAIL back_to_back: got nothing, required %s@%0d", e.kind.name(), e.cyc);
      end else begin
        a = act_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL back_to_back: got %s@%0d addr=%h, required %s@%0d addr=%h",
                   a.kind.name(), a.cyc, a.addr, e.kind.name(), e.cyc, e.addr);
        end
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back_extra: got %0d extra events, required 0", act_q.size());
    end
    checks++;
    if (sr[1] !== exp_sr) begin
      failures++;
      $display("FAIL back_to_back_value: got %h, required %h", sr[1], exp_sr);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5C;
    mem[16'h0010] = 8'hAB;
    mem[16'h0011] = 8'hCD;
    mem[16'h0021] = 8'h5A;
    mem[16'hFFFF] = 8'h12;
    mem[16'h0000] = 8'h34;
    for (int k = 0; k < 2; k++) begin
      req_valid[k]  = 1'b0;
      req_word[k]   = 1'b0;
      req_addr[k]   = 16'h0000;
      preload_en[k] = 1'b0;
      prev_rdy[k]   = 1'b1;
    end
    preload_val = 16'h0000;
    test_reset();
    test_word_read();
    test_byte_read();
    test_boundaries();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
